// File: rtl/svc_soc_lifecycle.sv
// svc_soc_lifecycle: holds the CPU in reset after system reset, releases it,
// then supervises the run until a software exit store or a watchdog timeout.
// All outputs are registered. The only paths from inputs to outputs go
// through flops.
module svc_soc_lifecycle #(
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned WATCHDOG_CYCLES = 1_000_000,
  parameter logic [31:0] EXIT_ADDR       = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic        wr_valid,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        core_rst,
  output logic        running,
  output logic        done,
  output logic        timeout,
  output logic [31:0] exit_code,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
);

  localparam int unsigned HW = $clog2(RESET_CYCLES) + 1;
  localparam int unsigned WW = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_EXITED,
    S_TIMEOUT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [HW-1:0] r_hold_cnt;
  logic [WW-1:0] r_wd;

  logic          r_core_rst;
  logic          r_running;
  logic          r_done;
  logic          r_timeout;
  logic [31:0]   r_exit_code;
  logic [31:0]   r_cycle_count;
  logic [31:0]   r_retire_count;

  logic          w_exit_hit;
  logic          w_wd_expire;
  logic          w_core_rst_d;
  logic          w_running_d;

  // Only full-word stores to the exit register terminate the run.
  assign w_exit_hit  = wr_valid && (wr_addr == EXIT_ADDR) && (wr_strb == 4'hF);
  assign w_wd_expire = !retire && (r_wd == WD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and next values of the run/reset indicators.
  // The CPU reset is released one edge after RUN is entered. It is raised
  // again on the same edge that leaves RUN. running is its complement.
  always_comb begin
    w_next       = r_state;
    w_core_rst_d = 1'b1;
    w_running_d  = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_exit_hit) begin
          w_next = S_EXITED;
        end else if (w_wd_expire) begin
          w_next = S_TIMEOUT;
        end
      end
      S_EXITED:  w_next = S_EXITED;
      S_TIMEOUT: w_next = S_TIMEOUT;
      default:   w_next = S_HOLD;
    endcase
    if ((r_state == S_RUN) && (w_next == S_RUN)) begin
      w_core_rst_d = 1'b0;
      w_running_d  = 1'b1;
    end
  end

  // Hold counter, run counters, watchdog and sticky termination outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt     <= '0;
      r_wd           <= '0;
      r_core_rst     <= 1'b1;
      r_running      <= 1'b0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
      r_exit_code    <= '0;
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else begin
      r_core_rst <= w_core_rst_d;
      r_running  <= w_running_d;
      if ((r_state == S_HOLD) && (r_hold_cnt != HOLD_LAST)) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
      if (r_state == S_RUN) begin
        r_cycle_count <= r_cycle_count + 32'd1;
        if (retire) begin
          r_retire_count <= r_retire_count + 32'd1;
          r_wd           <= '0;
        end else begin
          r_wd <= r_wd + WW'(1);
        end
        if (w_next == S_EXITED) begin
          r_exit_code <= wr_data;
          r_done      <= 1'b1;
        end else if (w_next == S_TIMEOUT) begin
          r_exit_code <= '0;
          r_timeout   <= 1'b1;
          r_done      <= 1'b1;
        end
      end
    end
  end

  assign core_rst     = r_core_rst;
  assign running      = r_running;
  assign done         = r_done;
  assign timeout      = r_timeout;
  assign exit_code    = r_exit_code;
  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_svc_soc_lifecycle.sv
// Directed testbench for svc_soc_lifecycle with RESET_CYCLES=16 and
// WATCHDOG_CYCLES=8. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at the same point.
module tb_svc_soc_lifecycle;

  localparam logic [31:0] EXIT = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        core_rst;
  logic        running;
  logic        done;
  logic        timeout;
  logic [31:0] exit_code;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  svc_soc_lifecycle #(
    .RESET_CYCLES    (16),
    .WATCHDOG_CYCLES (8),
    .EXIT_ADDR       (EXIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .retire       (retire),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .core_rst     (core_rst),
    .running      (running),
    .done         (done),
    .timeout      (timeout),
    .exit_code    (exit_code),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    retire   = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_strb  = s;
  endtask

  task automatic run_retires(input int unsigned n);
    retire = 1'b1;
    repeat (n) tick;
    retire = 1'b0;
  endtask

  // Pulse rst for one edge, check reset values, then walk the 16 hold edges
  // while driving retires and exit stores that must be ignored. On return,
  // the first RUN edge (edge 16) has been taken.
  task automatic reset_release;
    idle();
    rst = 1'b1;
    tick;
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_retire_count", retire_count, 32'd0);
    rst = 1'b0;
    for (int e = 0; e < 16; e++) begin
      if (e < 15) begin
        retire = 1'b1;
        store(EXIT, 32'hDEAD_BEEF, 4'hF);
      end else begin
        idle();
      end
      tick;
      check("hold_core_rst", {31'd0, core_rst}, 32'd1);
      check("hold_running", {31'd0, running}, 32'd0);
    end
    check("hold_done", {31'd0, done}, 32'd0);
    check("hold_exit_code", exit_code, 32'd0);
    check("hold_retire_count", retire_count, 32'd0);
    check("hold_cycle_count", cycle_count, 32'd0);
    tick;
    check("run_core_rst", {31'd0, core_rst}, 32'd0);
    check("run_running", {31'd0, running}, 32'd1);
    check("run_cycle_count", cycle_count, 32'd1);
    check("run_retire_count", retire_count, 32'd0);
    check("run_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    // Exit with code 0 after 100 retires (edges 17..116), store at edge 117.
    reset_release();
    run_retires(100);
    store(EXIT, 32'h0000_0000, 4'hF);
    tick;
    idle();
    check("exit0_done", {31'd0, done}, 32'd1);
    check("exit0_timeout", {31'd0, timeout}, 32'd0);
    check("exit0_exit_code", exit_code, 32'd0);
    check("exit0_retire_count", retire_count, 32'd100);
    check("exit0_cycle_count", cycle_count, 32'd102);
    check("exit0_core_rst", {31'd0, core_rst}, 32'd1);
    check("exit0_running", {31'd0, running}, 32'd0);
    // Terminal state ignores further retires and stores.
    retire = 1'b1;
    store(EXIT, 32'h0000_0055, 4'hF);
    repeat (3) tick;
    idle();
    check("term_exit_code", exit_code, 32'd0);
    check("term_retire_count", retire_count, 32'd100);
    check("term_cycle_count", cycle_count, 32'd102);
    check("term_done", {31'd0, done}, 32'd1);
    check("term_core_rst", {31'd0, core_rst}, 32'd1);

    // Reset after EXITED, then exit with 42. The exit edge also retires.
    reset_release();
    run_retires(99);
    retire = 1'b1;
    store(EXIT, 32'h0000_002A, 4'hF);
    tick;
    idle();
    check("exit42_exit_code", exit_code, 32'd42);
    check("exit42_done", {31'd0, done}, 32'd1);
    check("exit42_timeout", {31'd0, timeout}, 32'd0);
    check("exit42_retire_count", retire_count, 32'd100);
    check("exit42_cycle_count", cycle_count, 32'd101);

    // Watchdog: retire at edge 17, then silence, so timeout occurs at edge 25.
    reset_release();
    run_retires(1);
    for (int k = 1; k <= 7; k++) begin
      tick;
      check("wd_quiet_timeout", {31'd0, timeout}, 32'd0);
      check("wd_quiet_done", {31'd0, done}, 32'd0);
    end
    tick;
    check("wd_timeout", {31'd0, timeout}, 32'd1);
    check("wd_done", {31'd0, done}, 32'd1);
    check("wd_exit_code", exit_code, 32'd0);
    check("wd_running", {31'd0, running}, 32'd0);
    check("wd_core_rst", {31'd0, core_rst}, 32'd1);
    check("wd_cycle_count", cycle_count, 32'd10);
    check("wd_retire_count", retire_count, 32'd1);

    // Retire on the 7th silent cycle prevents a timeout. Ignored stores follow.
    // Then an exit store and a watchdog expiry occur on the same edge (32).
    reset_release();
    run_retires(1);
    repeat (6) tick;
    run_retires(1);
    for (int k = 1; k <= 7; k++) begin
      idle();
      if (k == 2) store(EXIT, 32'h0000_0011, 4'h1);
      if (k == 4) store(EXIT + 32'd4, 32'h0000_0022, 4'hF);
      tick;
    end
    idle();
    check("wd7_running", {31'd0, running}, 32'd1);
    check("wd7_done", {31'd0, done}, 32'd0);
    check("wd7_timeout", {31'd0, timeout}, 32'd0);
    check("wd7_retire_count", retire_count, 32'd2);
    check("wd7_cycle_count", cycle_count, 32'd16);
    store(EXIT, 32'h1234_5678, 4'hF);
    tick;
    idle();
    check("race_done", {31'd0, done}, 32'd1);
    check("race_timeout", {31'd0, timeout}, 32'd0);
    check("race_exit_code", exit_code, 32'h1234_5678);
    check("race_cycle_count", cycle_count, 32'd17);
    check("race_running", {31'd0, running}, 32'd0);

    // rst pulsed mid-RUN restarts the full hold sequence.
    reset_release();
    run_retires(3);
    check("mid_retire_count", retire_count, 32'd3);
    reset_release();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/svc_soc_lifecycle.md
# svc_soc_lifecycle

Lifecycle sequencer for the simulated RISC-V SoC: it holds the CPU in reset for a fixed number of cycles after system reset, then releases it and supervises the run. It terminates the run either on a software exit store to a reserved MMIO address or on a watchdog timeout when no instruction retires for too long. It sits between the SoC top-level reset and the CPU. Its `done`, `timeout` and `exit_code` outputs drive the simulation wrapper's end-of-test handling.

## Interface
- `RESET_CYCLES`, 16: cycles `core_rst` stays high after `rst` deasserts; legal range ≥1.
- `WATCHDOG_CYCLES`, 1_000_000: consecutive non-retiring RUN cycles that trigger a timeout; legal range ≥2.
- `EXIT_ADDR`, 32'hFFFF_FFF0: word address of the exit register.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `retire` input 1: one-cycle pulse per retired instruction.
- `wr_valid` input 1: CPU data-store strobe.
- `wr_addr` input 32: store address.
- `wr_data` input 32: store data.
- `wr_strb` input 4: byte enables.
- `core_rst` output 1: active-high reset to CPU and peripherals.
- `running` output 1: high in RUN.
- `done` output 1: sticky; high once the run has terminated by either cause.
- `timeout` output 1: sticky; high if termination was by watchdog.
- `exit_code` output 32: data of the exit store; 0 on timeout.
- `cycle_count` output 32: RUN cycles elapsed; wraps modulo 2^32.
- `retire_count` output 32: instructions retired in RUN; wraps modulo 2^32.

## Operation
- States: HOLD, RUN, EXITED, TIMEOUT. All are encoded registers; outputs are registered.
- HOLD: entered on `rst`.
  - `hold_cnt` counts 0 to RESET_CYCLES-1; `core_rst`=1.
  - On the cycle `hold_cnt`==RESET_CYCLES-1, go to RUN.
  - `retire` and stores are ignored in HOLD.
- RUN: `core_rst`=0, `running`=1.
  - `cycle_count` increments every cycle.
  - `retire_count` increments on `retire`.
  - Watchdog counter `wd` clears on `retire`, otherwise increments.
- Exit detect: `wr_valid` && `wr_addr`==EXIT_ADDR && `wr_strb`==4'hF in RUN. Partial-strobe stores to EXIT_ADDR are ignored.
  - Next state: EXITED. `exit_code`<=`wr_data`, `done`<=1.
- Watchdog expiry: in RUN with `retire`=0 and `wd`==WATCHDOG_CYCLES-1.
  - Next state: TIMEOUT. `timeout`<=1, `done`<=1, `exit_code`<=0.
- Simultaneous exit store and watchdog expiry in the same cycle: exit wins (EXITED, `timeout`=0).
- A `retire` in the same cycle as an exit store is counted.
- EXITED/TIMEOUT: terminal.
  - `core_rst`=1, which freezes the CPU.
  - Counters and `exit_code` hold.
  - Further stores and retires are ignored.
  - Only `rst` leaves these states.
- Reset values: state=HOLD, `core_rst`=1, `running`=0, `done`=0, `timeout`=0, `exit_code`=0, `cycle_count`=0, `retire_count`=0, `wd`=0, `hold_cnt`=0.
- `rst` asserted mid-RUN or in a terminal state: same-edge return to HOLD with all reset values; the hold sequence restarts in full.
- Internal counter widths: `$clog2` of the respective parameter + 1.

## Timing
- `rst` deasserted before edge 0.
  - `core_rst` is high through edge RESET_CYCLES-1 and falls after edge RESET_CYCLES.
  - First RUN cycle is cycle RESET_CYCLES.
- Exit store sampled at edge N: `done`, `exit_code` and `core_rst`=1 are visible after edge N. Latency is 1 cycle; `running` falls at the same edge.
- Timeout: with the last `retire` sampled at edge R, `timeout`/`done` rise after edge R+WATCHDOG_CYCLES. If no retire has occurred since RUN entry, they rise after edge RUN_start+WATCHDOG_CYCLES-1.
- `cycle_count` equals the number of RUN edges taken, including the terminating edge.
- No combinational input-to-output paths.

## Test plan
- Reset release, RESET_CYCLES=16 -> `core_rst`=1 for exactly 16 cycles after `rst` drops, then `running`=1; all outputs at reset values during HOLD.
- Retire every cycle for 100 cycles, then full-word store 32'h0000_0000 to EXIT_ADDR -> `done`=1 one cycle later, `timeout`=0, `exit_code`=0, `retire_count`=100, `core_rst`=1. Repeat with data 32'h0000_002A -> `exit_code`=42.
- WATCHDOG_CYCLES=8, single retire then silence -> `timeout`=`done`=1 exactly 8 edges after the retire edge, `exit_code`=0. Retire on the 7th silent cycle instead -> no timeout.
- Exit store and watchdog expiry on the same edge -> EXITED, `timeout`=0, `exit_code`=store data. Store with `wr_strb`=4'h1 to EXIT_ADDR, or a full store to EXIT_ADDR+4 -> ignored, still RUN.
- Exit store driven during HOLD -> ignored. `rst` pulsed one cycle mid-RUN, and again after EXITED -> full 16-cycle hold replay, counters zeroed, `done` cleared.
